// File: rtl/alu_pkg.sv
// Shared opcodes, NOP encoding and command-entry layout for the ALU issue queue.
package alu_pkg;

  localparam int unsigned INST_W    = 2;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned REP_W_DEF = 4;
  localparam int unsigned DEPTH_DEF = 4;

  localparam logic [INST_W-1:0] OP_ADD = 2'b00;
  localparam logic [INST_W-1:0] OP_SUB = 2'b01;
  localparam logic [INST_W-1:0] OP_MUL = 2'b10;
  localparam logic [INST_W-1:0] OP_AND = 2'b11;

  // The ALU runs every cycle, so "ADD 0" is what an idle cycle looks like.
  localparam logic [INST_W-1:0] NOP_INST = OP_ADD;
  localparam logic [DATA_W-1:0] NOP_A    = 8'h00;

  // Each queued entry is packed as {clr, rep, inst, a}.
  function automatic int unsigned entry_w(input int unsigned rep_w);
    return 1 + rep_w + INST_W + DATA_W;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of command entries; no write-to-read bypass.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PW'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Command queue and one-op-per-cycle sequencer feeding the accumulator ALU.
// Optional issue counter enabled by defining ALU_ISSUE_STAT_EN.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned REP_W = REP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [INST_W-1:0] cmd_inst,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [REP_W-1:0]  cmd_rep,
  input  logic              cmd_clr,
  output logic [INST_W-1:0] alu_inst,
  output logic [DATA_W-1:0] alu_a,
  output logic              alu_rst,
`ifdef ALU_ISSUE_STAT_EN
  output logic [15:0]       issue_cnt,
`endif
  output logic              busy
);

  localparam int unsigned ENTRY_W = entry_w(REP_W);

  typedef struct packed {
    logic              clr;
    logic [REP_W-1:0]  rep;
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] a;
  } entry_t;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_d;
  logic [INST_W-1:0] inst_d;
  logic [DATA_W-1:0] a_d;
  logic              arst_d;
  logic              load;
  logic              pop;
  logic              push;
  logic              full;
  logic              empty;
  entry_t            wr_entry;
  entry_t            head;
  logic [ENTRY_W-1:0] head_raw;

  assign cmd_ready = rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign wr_entry  = '{clr: cmd_clr, rep: cmd_rep, inst: cmd_inst, a: cmd_a};
  assign head      = entry_t'(head_raw);
  assign busy      = (state_q == S_RUN) || !empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (ENTRY_W'(wr_entry)),
    .pop   (pop),
    .rdata (head_raw),
    .full  (full),
    .empty (empty)
  );

  // Next state and next issued op: repeat, load the head without a bubble, or fall back to NOP.
  always_comb begin
    state_d = state_q;
    rep_d   = rep_cnt_q;
    inst_d  = alu_inst;
    a_d     = alu_a;
    arst_d  = alu_rst;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          load = 1'b1;
        end else begin
          inst_d = NOP_INST;
          a_d    = NOP_A;
          arst_d = 1'b1;
        end
      end
      S_RUN: begin
        if (rep_cnt_q != '0) begin
          rep_d = rep_cnt_q - REP_W'(1);
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
          inst_d  = NOP_INST;
          a_d     = NOP_A;
          arst_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      state_d = S_RUN;
      rep_d   = head.rep;
      inst_d  = head.clr ? NOP_INST : head.inst;
      a_d     = head.clr ? NOP_A : head.a;
      arst_d  = !head.clr;
    end
  end

  // State, repeat counter and issue registers; reset holds the ALU in reset too.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rep_cnt_q <= '0;
      alu_inst  <= NOP_INST;
      alu_a     <= NOP_A;
      alu_rst   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_d;
      alu_inst  <= inst_d;
      alu_a     <= a_d;
      alu_rst   <= arst_d;
    end
  end

`ifdef ALU_ISSUE_STAT_EN
  logic nonnop_d;
  assign nonnop_d = !arst_d || (inst_d != NOP_INST) || (a_d != NOP_A);

  // Count every cycle that issues something other than the ADD-0 NOP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_cnt <= '0;
    end else if (nonnop_d) begin
      issue_cnt <= issue_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized scoreboard bench for alu_issue_queue; issue_cnt checked when ALU_ISSUE_STAT_EN is defined.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned REP_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_inst = 2'b00;
  logic [7:0]        cmd_a = 8'h00;
  logic [REP_W-1:0]  cmd_rep = '0;
  logic              cmd_clr = 1'b0;
  logic [1:0]        alu_inst;
  logic [7:0]        alu_a;
  logic              alu_rst;
  logic              busy;
`ifdef ALU_ISSUE_STAT_EN
  logic [15:0]       issue_cnt;
`endif

  alu_issue_queue #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_inst  (cmd_inst),
    .cmd_a     (cmd_a),
    .cmd_rep   (cmd_rep),
    .cmd_clr   (cmd_clr),
    .alu_inst  (alu_inst),
    .alu_a     (alu_a),
    .alu_rst   (alu_rst),
`ifdef ALU_ISSUE_STAT_EN
    .issue_cnt (issue_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One expected issued ALU cycle; first marks the cycle that dequeues its command.
  typedef struct {
    logic [1:0] inst;
    logic [7:0] a;
    logic       clr;
    bit         first;
    int         acc;
  } op_t;

  op_t        opq[$];
  int         queued_cmds = 0;
  int         edge_n = 0;
  bit         rst_edge = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] exp_cnt = 16'h0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endfunction

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor for the latest edge, then record any command accepted at the coming edge.
  always @(negedge clk) begin
    logic [1:0] e_inst;
    logic [7:0] e_a;
    logic       e_rst;
    bit         e_cmd;
    op_t        o;
    if (edge_n > 0) begin
      e_cmd = 1'b0;
      if (!rst_edge) begin
        opq.delete();
        queued_cmds = 0;
        e_inst = 2'b00; e_a = 8'h00; e_rst = 1'b0;
        exp_cnt = 16'h0;
      end else if (opq.size() > 0 && opq[0].acc < edge_n) begin
        o = opq.pop_front();
        if (o.first) queued_cmds--;
        e_cmd  = 1'b1;
        e_inst = o.clr ? 2'b00 : o.inst;
        e_a    = o.clr ? 8'h00 : o.a;
        e_rst  = !o.clr;
      end else begin
        e_inst = 2'b00; e_a = 8'h00; e_rst = 1'b1;
      end
      if (rst_edge && (!e_rst || e_inst != 2'b00 || e_a != 8'h00)) exp_cnt = exp_cnt + 16'd1;
      chk("alu_inst", int'(alu_inst), int'(e_inst));
      chk("alu_a", int'(alu_a), int'(e_a));
      chk("alu_rst", int'(alu_rst), int'(e_rst));
      chk("busy", int'(busy), int'(e_cmd || queued_cmds > 0));
      chk("cmd_ready", int'(cmd_ready), int'(rst && queued_cmds < int'(DEPTH)));
`ifdef ALU_ISSUE_STAT_EN
      chk("issue_cnt", int'(issue_cnt), int'(exp_cnt));
`endif
    end
    if (rst && cmd_valid && cmd_ready) begin
      for (int r = 0; r <= int'(cmd_rep); r++)
        opq.push_back('{inst: cmd_inst, a: cmd_a, clr: cmd_clr, first: (r == 0), acc: edge_n + 1});
      queued_cmds++;
    end
    rst_edge = rst;
  end

  task automatic send(input logic [1:0] i, input logic [7:0] a, input int rep, input logic clr);
    bit acc;
    cmd_valid = 1'b1; cmd_inst = i; cmd_a = a; cmd_rep = REP_W'(rep); cmd_clr = clr;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (n > 500) begin
        errors++;
        $display("FAIL send_timeout: command not accepted after %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      if (opq.size() == 0 && queued_cmds == 0) return;
      @(posedge clk); #1;
    end
    errors++;
    $display("FAIL drain_timeout: %0d ops still expected", opq.size());
  endtask

  initial begin
    // Reset held for three edges.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    // Single op, then a repeated SUB.
    send(OP_ADD, 8'd5, 0, 1'b0); idle(3);
    send(OP_SUB, 8'd1, 3, 1'b0); idle(6);
    // Back-to-back ADD, MUL, AND, clear.
    send(OP_ADD, 8'd3, 0, 1'b0);
    send(OP_MUL, 8'd2, 0, 1'b0);
    send(OP_AND, 8'h0F, 0, 1'b0);
    send(OP_ADD, 8'hAA, 0, 1'b1);
    idle(6);
    // Fill the queue behind a long-running command.
    send(OP_ADD, 8'd1, 15, 1'b0);
    for (int k = 0; k < 6; k++) send(2'(k), 8'(8'h10 + k), k % 2, 1'b0);
    idle(1); drain(); idle(2);
    // Reset in the middle of a repeated command with more queued.
    send(OP_ADD, 8'd2, 7, 1'b0);
    send(OP_SUB, 8'd9, 1, 1'b0);
    idle(3);
    rst = 1'b0; idle(2); rst = 1'b1; idle(3);
    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      cmd_valid = $urandom_range(1);
      cmd_inst  = 2'($urandom);
      cmd_a     = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      cmd_rep   = ($urandom_range(3) == 0) ? REP_W'($urandom) : REP_W'($urandom_range(1));
      cmd_clr   = ($urandom_range(7) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b1; cmd_valid = 1'b0;
    drain(); idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
